// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-stage PC register plus IF/ID pipeline register. Issues sequential
//   fetches at pc_q (next PC = pc_q + 4, wrapping at 2^32), accepts branch
//   redirects from EX and stalls from the hazard unit. A one-entry skid
//   buffer catches a word that returns in the same cycle a stall arrives.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall             hold IF/ID, stop PC advancing into decode
//   branch_taken      redirect request; branch_target[1:0] ignored
//   imem_req/addr     fetch request and address (addr == pc_out)
//   imem_ready/rdata  fetch response for the current imem_addr
//   pc_out            current PC register
//   if_id_*           instruction, its PC+4, and valid flag to decode
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  // HOLD means the skid buffer holds a word not yet delivered to decode.
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_rec_t;

  state_t     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_rec_t skid_q, skid_d;
  fetch_rec_t ifid_q, ifid_d;
  logic       vld_q, vld_d;

  logic        fetch_done;
  logic [31:0] pc4;

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign fetch_done = imem_req & imem_ready;
  assign pc4        = pc_q + 32'd4;

  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc4;
  assign if_id_valid    = vld_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    ifid_d  = ifid_q;
    vld_d   = vld_q;
    if (branch_taken) begin
      // Flush wins over stall; any in-flight response and the skid are dropped.
      pc_d         = {branch_target[31:2], 2'b00};
      state_d      = FETCH;
      skid_d       = {NOP_INSTR, 32'h0};
      ifid_d.instr = NOP_INSTR;
      vld_d        = 1'b0;
    end else if (stall) begin
      if (state_q == FETCH && fetch_done) begin
        // Word arrived while decode is frozen: park it and move PC on.
        skid_d  = {imem_rdata, pc4};
        pc_d    = pc4;
        state_d = HOLD;
      end
    end else if (state_q == HOLD) begin
      // PC already advanced when the word was parked.
      ifid_d  = skid_q;
      vld_d   = 1'b1;
      state_d = FETCH;
    end else if (fetch_done) begin
      ifid_d = {imem_rdata, pc4};
      vld_d  = 1'b1;
      pc_d   = pc4;
    end else begin
      ifid_d.instr = NOP_INSTR;
      vld_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= {NOP_INSTR, 32'h0};
      ifid_q  <= {NOP_INSTR, 32'h0};
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      ifid_q  <= ifid_d;
      vld_q   <= vld_d;
    end
  end

endmodule
